mem_sram_stage: RTL

MEM_SRAM_STAGE -- requirements
Module: mem_sram_stage

---
 rtl/mem_sram_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_sram_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_sram_stage
// Description : Memory stage of a 32-bit pipeline backed by an external
//               16-bit asynchronous SRAM. Each 32-bit load/store is split into
//               a low half-word access followed by a high half-word access,
//               each lasting WAIT_CYC clocks. While the access runs, freeze
//               stalls the upstream pipeline and the MEM/WB register takes
//               bubbles. Non-memory instructions pass straight through.
// Ports       : clk, rst (async, active-low)
//               alu_res_in/val_Rm_in/dst_in/mem_read_in/mem_write_in/WB_en_in
//                 - execute-stage results and control
//               freeze - upstream stall request (combinational)
//               WB_en_out/mem_read_out/dst_out/alu_res_out/mem_data_out
//                 - registered MEM/WB pipeline register
//               sram_addr/sram_dq_out/sram_dq_oe/sram_we_n/sram_dq_in
//                 - external 16-bit SRAM interface
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sram_stage #(
    parameter int unsigned WAIT_CYC  = 2,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_Rm_in,
    input  logic [3:0]  dst_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        WB_en_in,
    output logic        freeze,
    output logic        WB_en_out,
    output logic        mem_read_out,
    output logic [3:0]  dst_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] mem_data_out,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    input  logic [15:0] sram_dq_in
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter value on the final clock of a half-word access.
    localparam logic [2:0] c_last = 3'(WAIT_CYC - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [15:0] r_lo_buf;
    logic [15:0] r_hi_buf;
    logic [16:0] r_word;
    logic [31:0] r_wdata;
    logic        r_is_write;

    logic [31:0] w_off;
    logic [16:0] w_word;
    logic        w_unused_off;
    logic        w_req;
    logic        w_access;
    logic        w_half;
    logic        w_wr_cycle;
    logic        w_freeze;

    // Word index inside the SRAM; byte lane and high address bits are dropped.
    assign w_off        = alu_res_in - BASE_ADDR;
    assign w_word       = w_off[18:2];
    assign w_unused_off = ^{w_off[31:19], w_off[1:0]};
    assign w_req        = mem_read_in | mem_write_in;

    always_comb begin
        w_access   = (r_state == S_LO) || (r_state == S_HI);
        w_half     = (r_state == S_HI);
        w_wr_cycle = w_access && r_is_write;
        // Gated by rst so a pending request cannot stall upstream during reset.
        w_freeze   = rst && (w_access || ((r_state == S_IDLE) && w_req));
    end

    assign freeze      = w_freeze;
    assign sram_addr   = w_access ? {r_word, w_half} : 18'd0;
    assign sram_dq_oe  = w_wr_cycle;
    assign sram_we_n   = ~w_wr_cycle;
    assign sram_dq_out = w_wr_cycle ? (w_half ? r_wdata[31:16] : r_wdata[15:0]) : 16'd0;

    // Access sequencer. The request is latched in IDLE so later input changes
    // cannot disturb an access already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_lo_buf   <= 16'd0;
            r_hi_buf   <= 16'd0;
            r_word     <= 17'd0;
            r_wdata    <= 32'd0;
            r_is_write <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_state    <= S_LO;
                        r_cnt      <= 3'd0;
                        r_word     <= w_word;
                        r_wdata    <= val_Rm_in;
                        // A simultaneous read+write request is served as a write.
                        r_is_write <= mem_write_in;
                    end
                end
                S_LO: begin
                    if (r_cnt == c_last) begin
                        r_state <= S_HI;
                        r_cnt   <= 3'd0;
                        if (!r_is_write) begin
                            r_lo_buf <= sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_HI: begin
                    if (r_cnt == c_last) begin
                        r_state <= S_DONE;
                        r_cnt   <= 3'd0;
                        if (!r_is_write) begin
                            r_hi_buf <= sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // MEM/WB pipeline register: bubbles while frozen, otherwise loads the
    // instruction; load data is only taken when a read access just completed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_en_out    <= 1'b0;
            mem_read_out <= 1'b0;
            dst_out      <= 4'd0;
            alu_res_out  <= 32'd0;
            mem_data_out <= 32'd0;
        end else if (w_freeze) begin
            WB_en_out    <= 1'b0;
            mem_read_out <= 1'b0;
        end else begin
            WB_en_out    <= WB_en_in;
            mem_read_out <= mem_read_in & ~mem_write_in;
            dst_out      <= dst_in;
            alu_res_out  <= alu_res_in;
            if ((r_state == S_DONE) && !r_is_write) begin
                mem_data_out <= {r_hi_buf, r_lo_buf};
            end
        end
    end

endmodule
`default_nettype wire
